// File: rtl/alu_pkg.sv
// Shared opcode and port-id constants for the ALU arbiter slice.
// The ALU itself lives outside the arbiter.
package alu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned OPW  = 5;

   localparam logic [OPW-1:0] OP_ADD  = 5'd0;
   localparam logic [OPW-1:0] OP_SUB  = 5'd1;
   localparam logic [OPW-1:0] OP_SLT  = 5'd2;
   localparam logic [OPW-1:0] OP_SLTU = 5'd3;
   localparam logic [OPW-1:0] OP_AND  = 5'd4;
   localparam logic [OPW-1:0] OP_OR   = 5'd5;
   localparam logic [OPW-1:0] OP_XOR  = 5'd6;
   localparam logic [OPW-1:0] OP_SLL  = 5'd7;
   localparam logic [OPW-1:0] OP_SRL  = 5'd8;
   localparam logic [OPW-1:0] OP_SRA  = 5'd9;
   localparam logic [OPW-1:0] OP_SRC0 = 5'd10;
   localparam logic [OPW-1:0] OP_SRC1 = 5'd11;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last port granted
// and only moves when a grant is actually taken.
module rr_arb2
   import alu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_req0,
   input  logic i_req1,
   output logic o_gnt0,
   output logic o_gnt1,
   output logic o_port
);

   logic r_last;
   logic w_pick1;

   // port 1 wins on contention unless it was the last one served
   assign w_pick1 = i_req1 & (~i_req0 | (r_last == PORT0));
   assign o_gnt1  = i_en & w_pick1;
   assign o_gnt0  = i_en & i_req0 & ~w_pick1;
   assign o_port  = w_pick1 ? PORT1 : PORT0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= PORT0;
      end else if (o_gnt0 | o_gnt1) begin
         r_last <= o_port;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters through a two-stage
// pipeline: stage A holds ALU operands, stage B holds the result.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   input  logic            req1_valid,
   output logic            req0_ready,
   output logic            req1_ready,
   input  logic [XLEN-1:0] req0_src0,
   input  logic [XLEN-1:0] req0_src1,
   input  logic [XLEN-1:0] req1_src0,
   input  logic [XLEN-1:0] req1_src1,
   input  logic [OPW-1:0]  req0_op,
   input  logic [OPW-1:0]  req1_op,
   output logic [XLEN-1:0] alu_src0,
   output logic [XLEN-1:0] alu_src1,
   output logic [OPW-1:0]  alu_op,
   input  logic [XLEN-1:0] alu_res,
   output logic            rsp0_valid,
   output logic            rsp1_valid,
   input  logic            rsp0_ready,
   input  logic            rsp1_ready,
   output logic [XLEN-1:0] rsp_data
);

   logic            r_a_valid;
   logic            r_a_owner;
   logic [XLEN-1:0] r_src0;
   logic [XLEN-1:0] r_src1;
   logic [OPW-1:0]  r_op;
   logic            r_b_valid;
   logic            r_b_owner;
   logic [XLEN-1:0] r_rsp;

   logic w_b_adv;
   logic w_a_move;
   logic w_a_open;
   logic w_gnt0;
   logic w_gnt1;
   logic w_port;
   logic w_acc;

   // B frees up when empty or when its owner takes the result
   assign w_b_adv  = ~r_b_valid | (r_b_owner ? rsp1_ready : rsp0_ready);
   assign w_a_move = r_a_valid & w_b_adv;
   assign w_a_open = ~rst & (~r_a_valid | w_a_move);
   assign w_acc    = w_gnt0 | w_gnt1;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_a_open),
      .i_req0 (req0_valid),
      .i_req1 (req1_valid),
      .o_gnt0 (w_gnt0),
      .o_gnt1 (w_gnt1),
      .o_port (w_port)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_valid <= 1'b0;
         r_a_owner <= PORT0;
         r_src0    <= '0;
         r_src1    <= '0;
         r_op      <= OP_ADD;
      end else if (w_acc) begin
         r_a_valid <= 1'b1;
         r_a_owner <= w_port;
         r_src0    <= w_port ? req1_src0 : req0_src0;
         r_src1    <= w_port ? req1_src1 : req0_src1;
         r_op      <= w_port ? req1_op : req0_op;
      end else if (w_a_move) begin
         r_a_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_b_valid <= 1'b0;
         r_b_owner <= PORT0;
         r_rsp     <= '0;
      end else if (w_b_adv) begin
         r_b_valid <= r_a_valid;
         if (r_a_valid) begin
            r_b_owner <= r_a_owner;
            r_rsp     <= alu_res;
         end
      end
   end

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;
   assign alu_src0   = r_src0;
   assign alu_src1   = r_src1;
   assign alu_op     = r_op;
   assign rsp0_valid = ~rst & r_b_valid & (r_b_owner == PORT0);
   assign rsp1_valid = ~rst & r_b_valid & (r_b_owner == PORT1);
   assign rsp_data   = r_rsp;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a behavioural ALU and
// an occupancy-based model of acceptance and round-robin order.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_src0, req0_src1, req1_src0, req1_src1;
   logic [4:0]  req0_op, req1_op;
   logic [31:0] alu_src0, alu_src1;
   logic [4:0]  alu_op;
   logic [31:0] alu_res;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [31:0] rsp_data;

   typedef struct {
      logic        port;
      logic [31:0] data;
   } item_t;

   item_t       sb[$];
   logic        glog[$];
   logic        m_ptr;
   logic [31:0] last0, last1;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(input logic [4:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << b[4:0];
         OP_SRL:  return a >> b[4:0];
         OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         OP_SRC0: return a;
         OP_SRC1: return b;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_res = alu_ref(alu_op, alu_src0, alu_src1);

   alu_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .req0_src0  (req0_src0),
      .req0_src1  (req0_src1),
      .req1_src0  (req1_src0),
      .req1_src1  (req1_src1),
      .req0_op    (req0_op),
      .req1_op    (req1_op),
      .alu_src0   (alu_src0),
      .alu_src1   (alu_src1),
      .alu_op     (alu_op),
      .alu_res    (alu_res),
      .rsp0_valid (rsp0_valid),
      .rsp1_valid (rsp1_valid),
      .rsp0_ready (rsp0_ready),
      .rsp1_ready (rsp1_ready),
      .rsp_data   (rsp_data)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // monitor: predicts readies from pipeline occupancy, pops responses
   always @(negedge clk) begin
      logic can, w1, e0, e1;
      if (rst) begin
         chk("rst_req0_ready", {31'd0, req0_ready}, 0);
         chk("rst_req1_ready", {31'd0, req1_ready}, 0);
         chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 0);
         sb.delete();
         m_ptr = 1'b0;
      end else begin
         can = (sb.size() < 2) || (sb[0].port ? rsp1_ready : rsp0_ready);
         w1  = req1_valid && (!req0_valid || m_ptr == 1'b0);
         e1  = can && w1;
         e0  = can && req0_valid && !w1;
         chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
         chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
         if (rsp0_valid || rsp1_valid) begin
            if (sb.size() == 0) begin
               chk("rsp_stale", {30'd0, rsp1_valid, rsp0_valid}, 0);
            end else begin
               chk("rsp_both", {30'd0, rsp1_valid, rsp0_valid},
                   sb[0].port ? 32'd2 : 32'd1);
               chk("rsp_data", rsp_data, sb[0].data);
               if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                  if (sb[0].port) last1 = rsp_data;
                  else last0 = rsp_data;
                  void'(sb.pop_front());
               end
            end
         end
         if (e0) begin
            sb.push_back('{1'b0, alu_ref(req0_op, req0_src0, req0_src1)});
            m_ptr = 1'b0;
            glog.push_back(1'b0);
         end
         if (e1) begin
            sb.push_back('{1'b1, alu_ref(req1_op, req1_src0, req1_src1)});
            m_ptr = 1'b1;
            glog.push_back(1'b1);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req0_valid = 0;
      req1_valid = 0;
      rsp0_ready = 1;
      rsp1_ready = 1;
      repeat (n) cyc();
   endtask

   task automatic set0(input logic [4:0] op, input logic [31:0] a, b);
      req0_op = op; req0_src0 = a; req0_src1 = b;
   endtask

   task automatic set1(input logic [4:0] op, input logic [31:0] a, b);
      req1_op = op; req1_src0 = a; req1_src1 = b;
   endtask

   initial begin
      int n;
      logic [31:0] x0;
      logic d0, d1;
      rst = 1;
      req0_valid = 0; req1_valid = 0;
      rsp0_ready = 1; rsp1_ready = 1;
      set0(OP_ADD, 0, 0);
      set1(OP_ADD, 0, 0);
      repeat (2) cyc();
      rst = 0;
      @(negedge clk);
      chk("reset_alu_op", {27'd0, alu_op}, {27'd0, OP_ADD});
      chk("reset_alu_src0", alu_src0, 0);
      chk("reset_rsp_data", rsp_data, 0);
      cyc();

      // single ADD, latency one cycle after accept
      set0(OP_ADD, 5, 7);
      req0_valid = 1;
      @(negedge clk);
      chk("single_ready", {31'd0, req0_ready}, 1);
      cyc();
      req0_valid = 0;
      @(negedge clk);
      chk("single_not_early", {31'd0, rsp0_valid}, 0);
      cyc();
      @(negedge clk);
      chk("single_rsp0_valid", {31'd0, rsp0_valid}, 1);
      chk("single_rsp1_valid", {31'd0, rsp1_valid}, 0);
      chk("single_data", rsp_data, 12);
      idle(3);

      // contention: grants alternate starting with port 1
      glog.delete();
      set0(OP_ADD, 1, 2);
      set1(OP_SUB, 10, 3);
      req0_valid = 1; req1_valid = 1;
      repeat (4) cyc();
      idle(4);
      chk("cont_grants", glog.size(), 4);
      if (glog.size() == 4)
         chk("cont_order", {28'd0, glog[0], glog[1], glog[2], glog[3]}, 32'hA);
      chk("cont_rsp1_data", last1, 7);

      // back-pressure on port 0 while streaming XOR
      rsp0_ready = 0;
      n = 0;
      set0(OP_XOR, 32'hF0F0_1234, 32'h0FF0_4321);
      x0 = 32'hF0F0_1234 ^ 32'h0FF0_4321;
      req0_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (req0_valid && req0_ready) n++;
         cyc();
         set0(OP_XOR, $urandom, $urandom);
      end
      @(negedge clk);
      chk("stall_accepts", n, 2);
      chk("stall_ready0", {31'd0, req0_ready}, 0);
      chk("stall_hold_data", rsp_data, x0);
      rsp0_ready = 1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (req0_valid && req0_ready) n++;
         cyc();
         set0(OP_XOR, $urandom, $urandom);
      end
      chk("release_accepts", n, 4);
      idle(4);

      // reset with both stages full
      rsp0_ready = 0;
      req0_valid = 1;
      set0(OP_SUB, 100, 1);
      repeat (3) cyc();
      req0_valid = 0;
      rst = 1;
      cyc();
      rst = 0;
      @(negedge clk);
      chk("rst_mid_valids", {30'd0, rsp1_valid, rsp0_valid}, 0);
      chk("rst_mid_alu_op", {27'd0, alu_op}, {27'd0, OP_ADD});
      chk("rst_mid_rsp_data", rsp_data, 0);
      idle(5);

      // signed vs unsigned compare, interleaved owners
      set0(OP_SLT, 32'hFFFF_FFFF, 1);
      set1(OP_SLTU, 32'hFFFF_FFFF, 1);
      req0_valid = 1; req1_valid = 1;
      d0 = 0; d1 = 0;
      for (int i = 0; i < 8 && !(d0 && d1); i++) begin
         @(negedge clk);
         if (req0_valid && req0_ready) d0 = 1;
         if (req1_valid && req1_ready) d1 = 1;
         cyc();
         if (d0) req0_valid = 0;
         if (d1) req1_valid = 0;
      end
      chk("order_accepted", {30'd0, d1, d0}, 3);
      idle(4);
      chk("order_rsp0", last0, 1);
      chk("order_rsp1", last1, 0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         rsp0_ready = ($urandom_range(0, 3) != 0);
         rsp1_ready = ($urandom_range(0, 3) != 0);
         set0(5'($urandom_range(0, 13)), $urandom, $urandom_range(0, 40));
         set1(5'($urandom_range(0, 13)), $urandom, $urandom);
         cyc();
      end
      idle(6);
      chk("drain_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
